mdu_unit: RTL



---
 rtl/mdu_unit_pkg.sv | 30 +++
 rtl/mdu_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared MDU opcode encodings and the start predicate used by both the MDU
// controller and the hazard-stall unit.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed
// single-shot from latched operands; the counter only paces Busy.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] op_a, op_b;
  logic [3:0]  op_q;
  logic        accept, finish;

  assign accept = (state == S_IDLE) && Start && is_md_start(MDUOp);
  assign finish = (state == S_RUN) && (cnt == CW'(1));

  // Product and quotient/remainder from the latched operands.
  logic [63:0] prod_s, prod_u;
  logic        div_signed, div_zero;
  logic [31:0] num, den, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    prod_s     = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    prod_u     = {32'b0, op_a} * {32'b0, op_b};
    div_signed = (op_q == MDU_DIV);
    div_zero   = (op_b == 32'd0);
    num        = (div_signed && op_a[31]) ? -op_a : op_a;
    den        = (div_signed && op_b[31]) ? -op_b : op_b;
    q_mag      = div_zero ? 32'd0 : num / den;
    r_mag      = div_zero ? 32'd0 : num % den;
    quo        = (div_signed && (op_a[31] ^ op_b[31])) ? -q_mag : q_mag;
    rem        = (div_signed && op_a[31]) ? -r_mag : r_mag;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    case (op_q)
      MDU_MULT:           begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MDU_MULTU:          begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MDU_DIV, MDU_DIVU:  begin res_hi = rem;           res_lo = quo;          end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_RUN;
      S_RUN:  if (finish) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == S_RUN);
    case (MDUOp)
      MDU_MFHI: Out = HI;
      MDU_MFLO: Out = LO;
      default:  Out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_a <= '0;
      op_b <= '0;
      op_q <= MDU_NONE;
      HI   <= '0;
      LO   <= '0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        op_a <= A;
        op_b <= B;
        op_q <= MDUOp;
        cnt  <= is_div_op(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (MDUOp == MDU_MTHI) begin
        HI <= A;
      end else if (MDUOp == MDU_MTLO) begin
        LO <= A;
      end
    end else begin
      cnt <= cnt - CW'(1);
      // A zero divisor still costs the full latency but leaves HI/LO intact.
      if (finish && !(is_div_op(op_q) && div_zero)) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end
  end

endmodule
